ysyx_22041207_pipe_stage: RTL

//   Generic, parametrised inter-stage pipeline register for the NPC core
//   (IF/ID, ID/EX, EX/ME, ME/WB). Replaces per-stage hand-written latches.

---
 rtl/ysyx_22041207_pipe_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/ysyx_22041207_pipe_stage.sv
// Inter-stage pipeline register: DEPTH-entry in-order buffer for an opaque payload.
// Latency: 1 cycle from push into an empty buffer to out_data; no same-cycle bypass.
// Backpressure: in_ready drops when full (unless PASS_READY and the head pops this cycle).
module ysyx_22041207_pipe_stage #(
    parameter int DATA_W     = 256,
    parameter int DEPTH      = 2,
    parameter int PASS_READY = 1,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    // A single-entry buffer still gets a 1-bit pointer; it never leaves zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic PASS = (PASS_READY != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              push;
    logic              pop;

    // Circular pointer advance, wrapping from the last entry back to zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;
    // Flush is deliberately absent here so in_ready never depends on a kill path.
    assign in_ready  = (occ_q < OCC_W'(DEPTH)) | (PASS & pop);
    assign push      = in_valid & in_ready & ~flush;

    // Empty slots read as zero so a bubble looks like an inserted NOP.
    assign out_data  = mem_q[rd_ptr_q] & {DATA_W{out_valid}};
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    // Next-state for pointers, occupancy and the saturating stall counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        stall_d  = stall_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
        // Flush does not touch the counter; it only measures downstream stalls.
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage; cleared on reset so out_data is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
